// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter with repeat count, inter-frame gap and abort
module seq_pattern_tx #(
  parameter int                 PAT_LEN    = 7,
  parameter logic [PAT_LEN-1:0] PATTERN    = 7'b1010101,
  parameter int                 CNT_W      = 4,
  parameter int                 GAP_W      = 4,
  parameter logic               IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);
  localparam int BW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t             state, state_n;
  logic [BW-1:0]      bit_idx, bit_idx_n;
  logic [PAT_LEN-1:0] sh, sh_n;
  logic [CNT_W-1:0]   frames, frames_n;
  logic [GAP_W-1:0]   gap_lat, gap_lat_n, gap_cnt, gap_cnt_n;
  logic               dout_n, valid_n, fs_n, busy_n, done_n, begin_frame, last_bit;
  assign last_bit = bit_idx == BW'(PAT_LEN - 1);
  // next state, counters and next registered outputs; sh holds the bits still to send
  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    sh_n        = sh;
    frames_n    = frames;
    gap_lat_n   = gap_lat;
    gap_cnt_n   = gap_cnt;
    dout_n      = IDLE_LEVEL;
    valid_n     = 1'b0;
    fs_n        = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    begin_frame = 1'b0;
    case (state)
      IDLE: if (start && repeat_n != '0 && !abort) begin
        begin_frame = 1'b1;
        frames_n    = repeat_n;
        gap_lat_n   = gap_n;
      end
      SEND: if (abort) state_n = IDLE;
      else if (!last_bit) begin
        bit_idx_n = bit_idx + BW'(1);
        dout_n    = sh[PAT_LEN-1];
        sh_n      = sh << 1;
        valid_n   = 1'b1;
        busy_n    = 1'b1;
      end else if (frames == CNT_W'(1)) begin
        state_n  = IDLE;
        frames_n = '0;
        done_n   = 1'b1;
      end else begin
        frames_n = frames - CNT_W'(1);
        busy_n   = 1'b1;
        if (gap_lat == '0) begin_frame = 1'b1;
        else begin
          state_n   = GAP;
          gap_cnt_n = gap_lat;
        end
      end
      GAP: if (abort) state_n = IDLE;
      else begin
        busy_n = 1'b1;
        if (gap_cnt == GAP_W'(1)) begin_frame = 1'b1;
        else gap_cnt_n = gap_cnt - GAP_W'(1);
      end
      default: state_n = IDLE;
    endcase
    if (begin_frame) begin
      state_n   = SEND;
      bit_idx_n = '0;
      sh_n      = PATTERN << 1;
      dout_n    = PATTERN[PAT_LEN-1];
      valid_n   = 1'b1;
      fs_n      = 1'b1;
      busy_n    = 1'b1;
    end
  end
  // state, counters and registered outputs with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_idx     <= '0;
      sh          <= '0;
      frames      <= '0;
      gap_lat     <= '0;
      gap_cnt     <= '0;
      dout        <= IDLE_LEVEL;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_idx     <= bit_idx_n;
      sh          <= sh_n;
      frames      <= frames_n;
      gap_lat     <= gap_lat_n;
      gap_cnt     <= gap_cnt_n;
      dout        <= dout_n;
      dout_valid  <= valid_n;
      frame_start <= fs_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] repeat_n = '0, gap_n = '0;
  logic       dout, dout_valid, frame_start, busy, done;
  logic [6:0] pat = 7'b1010101;
  int         n_tests = 0, n_fail = 0;

  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n), .gap_n(gap_n), .abort(abort),
    .dout(dout), .dout_valid(dout_valid), .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs();
    return {dout, dout_valid, frame_start, busy, done};
  endfunction

  // start already driven at the current negedge; check every cycle through done and one idle cycle
  task automatic check_stream(input int rn, input int gn, input bit hold, input string name);
    int total = rn * 7 + (rn - 1) * gn;
    logic [4:0] exp;
    for (int c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      if (!hold || c >= total) start = 1'b0;
      repeat_n = 4'd9;
      gap_n = 4'd7;
      if (c <= total) begin
        int pos = (c - 1) % (7 + gn);
        exp = (pos < 7) ? {pat[6-pos], 1'b1, pos == 0, 1'b1, 1'b0} : 5'b00010;
      end else exp = (c == total + 1) ? 5'b00001 : 5'b00000;
      check($sformatf("%s c%0d {dout,vld,fs,busy,done}", name, c), {27'd0, obs()}, {27'd0, exp});
    end
  endtask

  task automatic run_tx(input int rn, input int gn, input bit hold, input string name);
    @(negedge clk);
    start = 1'b1;
    repeat_n = 4'(rn);
    gap_n = 4'(gn);
    check_stream(rn, gn, hold, name);
  endtask

  initial begin
    #2;
    check("reset outputs", {27'd0, obs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_tx(1, 0, 0, "t1");
    run_tx(2, 0, 0, "t2");
    run_tx(2, 3, 0, "t3");
    // abort while the 4th bit is on dout, then restart on the following cycle
    @(negedge clk);
    start = 1'b1;
    repeat_n = 4'd1;
    gap_n = 4'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("t4 bit%0d dout", c), {31'd0, dout}, {31'd0, pat[7-c]});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4 after abort", {27'd0, obs()}, 32'd0);
    start = 1'b1;
    repeat_n = 4'd1;
    gap_n = 4'd0;
    check_stream(1, 0, 0, "t4r");
    // abort has priority over start in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    repeat_n = 4'd1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort beats start", {27'd0, obs()}, 32'd0);
    // start held throughout busy, then repeat_n==0 requests
    run_tx(2, 1, 1, "t5");
    start = 1'b1;
    repeat_n = 4'd0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("t5 rn0 c%0d", c), {27'd0, obs()}, 32'd0);
    end
    start = 1'b0;
    // asynchronous reset mid-frame
    @(negedge clk);
    start = 1'b1;
    repeat_n = 4'd3;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("t6 busy before rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check("t6 async rst", {27'd0, obs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_tx(1, 0, 0, "t6r");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
